// File: rtl/wb_stage.sv
// Write-back stage: registers ALU results and load data for the register-file write port,
// waiting on the data-memory handshake for loads. Writes to r15 are never committed.
module wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_wb_en,
  input  logic        mem_r_en,
  input  logic [3:0]  mem_dest,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] WB_Value,
  output logic [3:0]  WB_Dest,
  output logic        WB_EN,
  output logic        stall_req,
  output logic        mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [3:0]       R15         = 4'hF;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       lat_dest_q;
  logic             lat_wb_en_q;
  logic [31:0]      wb_value_q;
  logic [3:0]       wb_dest_q;
  logic             wb_en_q;
  logic             mem_err_q;
  logic             load_miss;

  assign load_miss = (state_q == S_IDLE) & mem_valid & mem_r_en & ~dmem_ready;
  assign stall_req = (state_q == S_WAIT) | load_miss;

  assign WB_Value = wb_value_q;
  assign WB_Dest  = wb_dest_q;
  assign WB_EN    = wb_en_q;
  assign mem_err  = mem_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_dest_q  <= '0;
      lat_wb_en_q <= 1'b0;
      wb_value_q  <= '0;
      wb_dest_q   <= '0;
      wb_en_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wb_en_q <= 1'b0;
          if (mem_valid) begin
            if (mem_r_en && !dmem_ready) begin
              // Load missed: hold dest/enable until the memory answers.
              lat_dest_q  <= mem_dest;
              lat_wb_en_q <= mem_wb_en;
              cnt_q       <= CNT_W'(1);
              state_q     <= S_WAIT;
            end else begin
              wb_value_q <= mem_r_en ? dmem_rdata : mem_alu_res;
              wb_dest_q  <= mem_dest;
              wb_en_q    <= mem_wb_en & (mem_dest != R15);
            end
          end
        end
        S_WAIT: begin
          wb_en_q <= 1'b0;
          if (dmem_ready) begin
            wb_value_q <= dmem_rdata;
            wb_dest_q  <= lat_dest_q;
            wb_en_q    <= lat_wb_en_q & (lat_dest_q != R15);
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else if (cnt_q >= TIMEOUT_CNT) begin
            mem_err_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: randomized ALU ops and loads against a
// transaction-level model of write-back latency, stall length and timeout.
module tb_wb_stage;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_wb_en, mem_r_en, dmem_ready;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_res, dmem_rdata;
  logic [31:0] WB_Value;
  logic [3:0]  WB_Dest;
  logic        WB_EN, stall_req, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  // model of the architecturally visible write-back register contents
  logic [31:0] m_val;
  logic [3:0]  m_dest;
  logic        m_err;

  wb_stage #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
    .mem_dest(mem_dest), .mem_alu_res(mem_alu_res),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .WB_Value(WB_Value), .WB_Dest(WB_Dest), .WB_EN(WB_EN),
    .stall_req(stall_req), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_dest = '0;
    mem_alu_res = '0; dmem_ready = 1'b0; dmem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one load whose data arrives k cycles after issue (k<0: never) and
  // records what the DUT showed; the calling test decides what was expected.
  task automatic do_load(input logic [3:0] d, input logic we, input logic [31:0] data,
                         input int k, output int st_cnt, output int en_cnt,
                         output int en_cyc, output logic [31:0] fval,
                         output logic [3:0] fdest, output logic ferr);
    int span;
    span = (k == 0) ? 1 : ((k > 0 && k <= T) ? k + 1 : T + 1);
    st_cnt = 0; en_cnt = 0; en_cyc = -1;
    for (int c = 0; c < span + 2; c++) begin
      if (c == 0) begin
        mem_valid = 1'b1; mem_r_en = 1'b1; mem_wb_en = we; mem_dest = d;
        mem_alu_res = $urandom;
      end else if (c < span) begin
        mem_valid = 1'($urandom_range(0, 1)); mem_r_en = 1'($urandom_range(0, 1));
        mem_wb_en = 1'($urandom_range(0, 1)); mem_dest = 4'($urandom);
        mem_alu_res = $urandom;
      end else begin
        idle_inputs();
      end
      dmem_ready = (c == k) ? 1'b1 : 1'b0;
      dmem_rdata = (c == k) ? data : $urandom;
      #1;
      if (stall_req) st_cnt++;
      tick();
      if (WB_EN) begin en_cnt++; en_cyc = c; end
    end
    fval = WB_Value; fdest = WB_Dest; ferr = mem_err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    mem_valid = 1'b1; mem_wb_en = 1'b1; mem_dest = 4'd3; mem_alu_res = 32'hDEAD_BEEF;
    tick(); tick();
    n_tests++; if (WB_Value !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h expected 0", WB_Value); end
    n_tests++; if (WB_Dest !== 4'h0) begin n_fail++; $display("FAIL reset_dest: got %h expected 0", WB_Dest); end
    n_tests++; if (WB_EN !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", WB_EN); end
    n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", mem_err); end
    n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    rst = 1'b1;
    idle_inputs();
    m_val = '0; m_dest = '0; m_err = 1'b0;
  endtask

  task automatic test_alu();
    logic v, we, re, e_en;
    logic [3:0] d;
    logic [31:0] a;
    mem_valid = 1'b1; mem_wb_en = 1'b1; mem_r_en = 1'b0; mem_dest = 4'd3; mem_alu_res = 32'h1234;
    #1;
    n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", stall_req); end
    tick();
    n_tests++; if ({WB_EN, WB_Dest, WB_Value} !== {1'b1, 4'd3, 32'h1234}) begin
      n_fail++; $display("FAIL alu_directed: got en=%b dest=%h val=%h expected en=1 dest=3 val=00001234", WB_EN, WB_Dest, WB_Value);
    end
    idle_inputs();
    tick();
    n_tests++; if ({WB_EN, WB_Value} !== {1'b0, 32'h1234}) begin
      n_fail++; $display("FAIL alu_pulse: got en=%b val=%h expected en=0 val=00001234", WB_EN, WB_Value);
    end
    m_val = 32'h1234; m_dest = 4'd3;
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      re = v ? 1'b0 : 1'($urandom_range(0, 1));
      d = 4'($urandom); a = $urandom;
      mem_valid = v; mem_wb_en = we; mem_r_en = re; mem_dest = d; mem_alu_res = a;
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      if (v) begin m_val = a; m_dest = d; end
      e_en = v && we && (d != 4'd15);
      #1;
      n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_rand_stall[%0d]: got %b expected 0", i, stall_req); end
      tick();
      n_tests++; if ({WB_EN, WB_Dest, WB_Value} !== {e_en, m_dest, m_val}) begin
        n_fail++; $display("FAIL alu_rand[%0d]: got en=%b dest=%h val=%h expected en=%b dest=%h val=%h",
                           i, WB_EN, WB_Dest, WB_Value, e_en, m_dest, m_val);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      d = 4'($urandom_range(0, 14)); a = $urandom;
      mem_valid = 1'b1; mem_wb_en = 1'b1; mem_r_en = 1'b0; mem_dest = d; mem_alu_res = a;
      m_val = a; m_dest = d;
      tick();
      n_tests++; if ({WB_EN, WB_Dest, WB_Value} !== {1'b1, d, a}) begin
        n_fail++; $display("FAIL b2b[%0d]: got en=%b dest=%h val=%h expected en=1 dest=%h val=%h", i, WB_EN, WB_Dest, WB_Value, d, a);
      end
    end
    idle_inputs();
    tick();
    n_tests++; if (WB_EN !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got en=%b expected 0", WB_EN); end
  endtask

  // Checks one load of delay k against the model; used by the load scenarios below.
  task automatic test_one_load(input string nm, input logic [3:0] d, input logic we,
                               input logic [31:0] data, input int k);
    int st, en, ec, e_st, e_en;
    logic [31:0] fv;
    logic [3:0] fd;
    logic fe;
    logic done;
    done = (k >= 0 && k <= T);
    e_st = (k == 0) ? 0 : (done ? k + 1 : T + 1);
    e_en = (done && we && d != 4'd15) ? 1 : 0;
    if (done) begin m_val = data; m_dest = d; end else m_err = 1'b1;
    do_load(d, we, data, k, st, en, ec, fv, fd, fe);
    n_tests++; if (st !== e_st) begin n_fail++; $display("FAIL %s_stall_cycles: got %0d expected %0d", nm, st, e_st); end
    n_tests++; if (en !== e_en) begin n_fail++; $display("FAIL %s_wb_en_count: got %0d expected %0d", nm, en, e_en); end
    if (e_en == 1) begin
      n_tests++; if (ec !== k) begin n_fail++; $display("FAIL %s_wb_cycle: got %0d expected %0d", nm, ec, k); end
    end
    n_tests++; if ({fd, fv, fe} !== {m_dest, m_val, m_err}) begin
      n_fail++; $display("FAIL %s_final: got dest=%h val=%h err=%b expected dest=%h val=%h err=%b",
                         nm, fd, fv, fe, m_dest, m_val, m_err);
    end
  endtask

  task automatic test_zero_wait_load();
    test_one_load("zw_directed", 4'd5, 1'b1, 32'hCAFE_F00D, 0);
    for (int i = 0; i < 6; i++)
      test_one_load("zw_rand", 4'($urandom), 1'($urandom_range(0, 1)), $urandom, 0);
  endtask

  task automatic test_wait_load();
    test_one_load("wait3_directed", 4'd7, 1'b1, 32'h0BAD_CAFE, 2);
    test_one_load("wait_k1", 4'd2, 1'b1, $urandom, 1);
    test_one_load("wait_kmax", 4'd9, 1'b1, $urandom, T);
    for (int i = 0; i < 8; i++)
      test_one_load("wait_rand", 4'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, T));
  endtask

  task automatic test_r15();
    mem_valid = 1'b1; mem_wb_en = 1'b1; mem_r_en = 1'b0; mem_dest = 4'd15; mem_alu_res = 32'h5555_AAAA;
    m_val = 32'h5555_AAAA; m_dest = 4'd15;
    tick();
    n_tests++; if ({WB_EN, WB_Dest, WB_Value} !== {1'b0, 4'd15, 32'h5555_AAAA}) begin
      n_fail++; $display("FAIL r15_alu: got en=%b dest=%h val=%h expected en=0 dest=f val=5555aaaa", WB_EN, WB_Dest, WB_Value);
    end
    idle_inputs();
    test_one_load("r15_load", 4'd15, 1'b1, 32'h1357_9BDF, 3);
  endtask

  task automatic test_timeout();
    test_one_load("timeout", 4'd4, 1'b1, 32'hFFFF_0000, -1);
    mem_valid = 1'b1; mem_wb_en = 1'b1; mem_r_en = 1'b0; mem_dest = 4'd1; mem_alu_res = 32'h77;
    tick();
    idle_inputs();
    n_tests++; if ({WB_EN, mem_err} !== 2'b11) begin
      n_fail++; $display("FAIL timeout_sticky: got en=%b err=%b expected en=1 err=1", WB_EN, mem_err);
    end
    m_val = 32'h77; m_dest = 4'd1;
  endtask

  task automatic test_reset_mid_wait();
    mem_valid = 1'b1; mem_wb_en = 1'b1; mem_r_en = 1'b1; mem_dest = 4'd6; mem_alu_res = $urandom;
    dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle_inputs();
    #1;
    n_tests++; if ({WB_EN, WB_Dest, WB_Value, mem_err, stall_req} !== {1'b0, 4'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_wait_outputs: got en=%b dest=%h val=%h err=%b stall=%b expected all 0",
                         WB_EN, WB_Dest, WB_Value, mem_err, stall_req);
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h9999_8888;
    tick();
    idle_inputs();
    n_tests++; if ({WB_EN, WB_Value} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_wait_late_ready: got en=%b val=%h expected en=0 val=0", WB_EN, WB_Value);
    end
    m_val = '0; m_dest = '0; m_err = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_alu();
    test_back_to_back();
    test_zero_wait_load();
    test_wait_load();
    test_r15();
    test_timeout();
    test_reset_mid_wait();
    test_one_load("post_reset_load", 4'd8, 1'b1, 32'hA5A5_5A5A, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
